// File: rtl/classifier_pkg.sv
// classifier_pkg: shared sizes, INT4/INT8 widths and sequencer state encoding for the output-layer classifier
package classifier_pkg;
  localparam int N_FEAT_D = 64;
  localparam int N_CLASSES_D = 8;
  localparam int CLASS_BITS_D = 3;
  localparam int DRAIN_D = 2;
  localparam int AW_D = $clog2(N_FEAT_D * N_CLASSES_D);
  localparam int INT4_W = 4;
  localparam int INT8_W = 8;
  typedef enum logic [2:0] {ST_IDLE, ST_RUN, ST_FLUSH, ST_DRAIN, ST_DONE} state_t;
endpackage

// File: rtl/classifier_feat_buf.sv
// classifier_feat_buf: N-entry INT4 register file with one write port and one asynchronous read port
module classifier_feat_buf
  import classifier_pkg::*;
#(
  parameter int N = N_FEAT_D,
  parameter int AW = $clog2(N)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [INT4_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [INT4_W-1:0] rdata
);
  logic [INT4_W-1:0] mem [N];
  always_ff @(posedge clk) if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/classifier_seq.sv
// classifier_seq: buffers one INT4 vector then streams class-major (feature, weight) pairs; CLASSIFIER_SEQ_ZERO_SKIP_EN suppresses new_feat for zero features
module classifier_seq
  import classifier_pkg::*;
#(
  parameter int N_FEAT = N_FEAT_D,
  parameter int N_CLASSES = N_CLASSES_D,
  parameter int CLASS_BITS = CLASS_BITS_D,
  parameter int DRAIN = DRAIN_D,
  parameter int AW = $clog2(N_FEAT * N_CLASSES)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  feat_valid,
  input  logic [INT4_W-1:0]     feat_data,
  output logic                  feat_ready,
  output logic [AW-1:0]         w_addr,
  input  logic [INT8_W-1:0]     w_rdata,
  output logic [INT4_W-1:0]     x_int4,
  output logic [INT8_W-1:0]     w_int8,
  output logic                  new_feat,
  output logic                  new_class,
  output logic [CLASS_BITS-1:0] class_id,
  output logic                  busy,
  output logic                  done
);
  localparam int FW = $clog2(N_FEAT);
  localparam int DW = $clog2(DRAIN + 2);
  state_t state, state_nx;
  logic [FW-1:0] f;
  logic [CLASS_BITS-1:0] c;
  logic [DW-1:0] d;
  logic [INT4_W-1:0] rd;
  logic wr, f_last, c_last, keep;
  assign feat_ready = state == ST_IDLE;
  assign wr = feat_ready && feat_valid;
  assign f_last = f == FW'(N_FEAT - 1);
  assign c_last = c == CLASS_BITS'(N_CLASSES - 1);
  assign w_int8 = w_rdata;
  assign busy = state inside {ST_RUN, ST_FLUSH, ST_DRAIN};
  assign done = state == ST_DONE;
`ifdef CLASSIFIER_SEQ_ZERO_SKIP_EN
  assign keep = rd != '0;
`else
  assign keep = 1'b1;
`endif
  classifier_feat_buf #(.N(N_FEAT)) u_buf (
    .clk(clk),
    .we(wr && !rst),
    .waddr(f),
    .wdata(feat_data),
    .raddr(f),
    .rdata(rd)
  );
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:  state_nx = wr && f_last ? ST_RUN : ST_IDLE;
      ST_RUN:   state_nx = f_last && c_last ? ST_FLUSH : ST_RUN;
      ST_FLUSH: state_nx = ST_DRAIN;
      ST_DRAIN: state_nx = d == DW'(DRAIN) ? ST_DONE : ST_DRAIN;
      default:  state_nx = ST_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      f <= '0;
      c <= '0;
      d <= '0;
      w_addr <= '0;
      x_int4 <= '0;
      new_feat <= 1'b0;
      new_class <= 1'b0;
      class_id <= '0;
    end else begin
      state <= state_nx;
      if (wr || state == ST_RUN) f <= f_last ? '0 : f + 1'b1;
      if (state == ST_RUN && f_last) c <= c_last ? '0 : c + 1'b1;
      if (state == ST_RUN) w_addr <= f_last && c_last ? '0 : w_addr + 1'b1;
      d <= state == ST_DRAIN ? d + 1'b1 : '0;
      if (state == ST_RUN && keep) x_int4 <= rd;
      new_feat <= state == ST_RUN && keep;
      new_class <= (state == ST_RUN && f == '0) || state == ST_FLUSH;
      class_id <= state == ST_RUN ? c : state == ST_FLUSH ? CLASS_BITS'(N_CLASSES - 1) : class_id;
    end
  end
endmodule

// File: tb/tb_classifier_seq.sv
// tb_classifier_seq: directed and randomized checks of classifier_seq against a cycle-timing reference model
module tb_classifier_seq;
  localparam int NF = 4;
  localparam int NC = 2;
  localparam int CB = 3;
  localparam int DR = 2;
  localparam int AW = 3;
  localparam int T_FL = NF * NC + 2;
  localparam int T_DN = T_FL + DR + 1;
  localparam int T_END = T_DN + 1;
`ifdef CLASSIFIER_SEQ_ZERO_SKIP_EN
  localparam bit ZS = 1'b1;
`else
  localparam bit ZS = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic feat_valid = 1'b0;
  logic [3:0] feat_data = 4'd0;
  logic feat_ready;
  logic [AW-1:0] w_addr;
  logic [7:0] w_rdata = 8'd0;
  logic [3:0] x_int4;
  logic [7:0] w_int8;
  logic new_feat, new_class, busy, done;
  logic [CB-1:0] class_id;
  logic [7:0] rom [NF*NC];
  int total = 0;
  int bad = 0;
  always #5 clk = ~clk;
  always @(posedge clk) w_rdata <= rom[w_addr];
  classifier_seq #(.N_FEAT(NF), .N_CLASSES(NC), .CLASS_BITS(CB), .DRAIN(DR), .AW(AW)) dut (
    .clk(clk),
    .rst(rst),
    .feat_valid(feat_valid),
    .feat_data(feat_data),
    .feat_ready(feat_ready),
    .w_addr(w_addr),
    .w_rdata(w_rdata),
    .x_int4(x_int4),
    .w_int8(w_int8),
    .new_feat(new_feat),
    .new_class(new_class),
    .class_id(class_id),
    .busy(busy),
    .done(done)
  );
  task automatic run_vec(input logic [3:0] fv [NF], input bit gap, input bit noise, output int max_c, output int max_s);
    int acc [NC];
    int want [NC];
    int k, f, c;
    bit prod, enf, have, ok;
    logic [3:0] last_x;
    logic [AW+2:0] ec;
    logic [1:0] es;
    for (int i = 0; i < NC; i++) begin
      acc[i] = 0;
      want[i] = 0;
      for (int j = 0; j < NF; j++) want[i] += int'($signed(fv[j])) * int'($signed(rom[i*NF+j]));
    end
    have = 1'b0;
    last_x = 4'd0;
    for (int i = 0; i < NF; i++) begin
      if (gap) begin
        feat_valid = 1'b0;
        @(posedge clk); #1;
      end
      feat_valid = 1'b1;
      feat_data = fv[i];
      @(negedge clk);
      total++;
      if (feat_ready !== 1'b1) begin
        bad++;
        $display("FAIL load_ready beat=%0d got=%b want=1", i, feat_ready);
      end
      @(posedge clk); #1;
    end
    feat_valid = noise;
    feat_data = 4'($urandom);
    for (int j = 1; j <= T_END; j++) begin
      @(negedge clk);
      prod = j >= 2 && j <= NF * NC + 1;
      k = prod ? j - 2 : 0;
      f = k % NF;
      c = k / NF;
      enf = prod && !(ZS && fv[f] == 4'd0);
      ec = {j == T_END, j < T_DN, j == T_DN, AW'(j <= NF * NC ? j - 1 : 0)};
      total++;
      if ({feat_ready, busy, done, w_addr} !== ec) begin
        bad++;
        $display("FAIL ctrl cyc=%0d got=%b want=%b", j, {feat_ready, busy, done, w_addr}, ec);
      end
      es = {enf, (prod && f == 0) || j == T_FL};
      total++;
      if ({new_feat, new_class} !== es) begin
        bad++;
        $display("FAIL strobes cyc=%0d got=%b want=%b", j, {new_feat, new_class}, es);
      end
      if (prod || j == T_FL) begin
        total++;
        if (class_id !== CB'(prod ? c : NC - 1)) begin
          bad++;
          $display("FAIL class_id cyc=%0d got=%0d want=%0d", j, class_id, prod ? c : NC - 1);
        end
      end
      if (enf) begin
        total++;
        if ({x_int4, w_int8} !== {fv[f], rom[k]}) begin
          bad++;
          $display("FAIL pair cyc=%0d got=%h/%h want=%h/%h", j, x_int4, w_int8, fv[f], rom[k]);
        end
        last_x = fv[f];
        have = 1'b1;
      end else if (have) begin
        total++;
        if (x_int4 !== last_x) begin
          bad++;
          $display("FAIL x_hold cyc=%0d got=%h want=%h", j, x_int4, last_x);
        end
      end
      if (new_feat === 1'b1 && class_id < CB'(NC)) acc[class_id] += int'($signed(x_int4)) * int'($signed(w_int8));
      if (j == T_DN) begin
        ok = 1'b1;
        for (int i = 0; i < NC; i++) ok &= acc[i] == want[i];
        total++;
        if (!ok) begin
          bad++;
          $display("FAIL scores got=%0d,%0d want=%0d,%0d", acc[0], acc[1], want[0], want[1]);
        end
      end
      @(posedge clk); #1;
      feat_valid = noise && j + 1 < T_END;
      feat_data = 4'($urandom);
    end
    feat_valid = 1'b0;
    max_c = acc[1] > acc[0] ? 1 : 0;
    max_s = acc[max_c];
  endtask
  task automatic test_reset();
    rst = 1'b1;
    feat_valid = 1'b1;
    feat_data = 4'd5;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if ({feat_ready, busy, done, w_addr, x_int4, new_feat, new_class, class_id} !== {1'b1, 14'd0}) begin
      bad++;
      $display("FAIL reset got=%b want=%b", {feat_ready, busy, done, w_addr, x_int4, new_feat, new_class, class_id}, {1'b1, 14'd0});
    end
    @(posedge clk); #1;
    rst = 1'b0;
    feat_valid = 1'b0;
  endtask
  task automatic test_basic();
    logic [3:0] v [NF];
    int mc, ms;
    v = '{4'd1, 4'd2, 4'd3, 4'd4};
    run_vec(v, 1'b0, 1'b0, mc, ms);
    total++;
    if (mc != 1 || ms != 70) begin
      bad++;
      $display("FAIL argmax got=%0d/%0d want=1/70", mc, ms);
    end
  endtask
  task automatic test_gapped();
    logic [3:0] v [NF];
    int mc, ms;
    v = '{4'd1, 4'd2, 4'd3, 4'd4};
    run_vec(v, 1'b1, 1'b1, mc, ms);
    total++;
    if (mc != 1 || ms != 70) begin
      bad++;
      $display("FAIL argmax_gapped got=%0d/%0d want=1/70", mc, ms);
    end
  endtask
  task automatic test_back_to_back();
    logic [3:0] v [NF];
    int mc, ms;
    v = '{4'd4, 4'd3, 4'd2, 4'd1};
    run_vec(v, 1'b0, 1'b0, mc, ms);
    v = '{4'hf, 4'd5, 4'hd, 4'd2};
    run_vec(v, 1'b0, 1'b1, mc, ms);
  endtask
  task automatic test_mid_reset();
    logic [3:0] v [NF];
    int mc, ms;
    bit quiet;
    for (int i = 0; i < NF; i++) begin
      feat_valid = 1'b1;
      feat_data = 4'(i + 9);
      @(posedge clk); #1;
    end
    feat_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    total++;
    if ({busy, w_addr} !== {1'b1, 3'd2}) begin
      bad++;
      $display("FAIL mid_run got=%b want=%b", {busy, w_addr}, {1'b1, 3'd2});
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    total++;
    if ({feat_ready, busy, done, w_addr, x_int4, new_feat, new_class, class_id} !== {1'b1, 14'd0}) begin
      bad++;
      $display("FAIL mid_reset got=%b want=%b", {feat_ready, busy, done, w_addr, x_int4, new_feat, new_class, class_id}, {1'b1, 14'd0});
    end
    quiet = 1'b1;
    repeat (20) begin
      @(negedge clk);
      quiet &= done === 1'b0 && busy === 1'b0 && feat_ready === 1'b1;
    end
    total++;
    if (!quiet) begin
      bad++;
      $display("FAIL post_reset_idle got=0 want=1");
    end
    @(posedge clk); #1;
    v = '{4'd6, 4'hb, 4'd1, 4'd7};
    run_vec(v, 1'b0, 1'b0, mc, ms);
  endtask
  task automatic test_extremes();
    logic [3:0] v [NF];
    int mc, ms;
    for (int a = 0; a < NF * NC; a++) rom[a] = 8'h80;
    v = '{4'h8, 4'h7, 4'h8, 4'h7};
    run_vec(v, 1'b0, 1'b0, mc, ms);
    for (int a = 0; a < NF * NC; a++) rom[a] = 8'(a + 1);
  endtask
  task automatic test_zero_skip();
    logic [3:0] v [NF];
    int mc, ms;
    v = '{4'd0, 4'd2, 4'd0, 4'd4};
    run_vec(v, 1'b0, 1'b0, mc, ms);
  endtask
  task automatic test_random();
    logic [3:0] v [NF];
    int mc, ms;
    for (int n = 0; n < 6; n++) begin
      for (int a = 0; a < NF * NC; a++) rom[a] = 8'($urandom);
      for (int i = 0; i < NF; i++) v[i] = $urandom_range(0, 3) == 0 ? 4'd0 : 4'($urandom);
      run_vec(v, 1'($urandom), 1'($urandom), mc, ms);
    end
  endtask
  initial begin
    for (int a = 0; a < NF * NC; a++) rom[a] = 8'(a + 1);
    test_reset();
    test_basic();
    test_gapped();
    test_back_to_back();
    test_mid_reset();
    test_extremes();
    test_zero_skip();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
